// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned LINE_W         = 256;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned OFFSET_W       = 5;
    localparam int unsigned MEM_ADDR_W     = 27;
    localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

    // Index and tag widths depend on the line count, so callers truncate the result.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned idx_w);
        return (addr >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned idx_w);
        return addr >> (OFFSET_W + idx_w);
    endfunction

    function automatic logic [MEM_ADDR_W-1:0] addr_line(input logic [31:0] addr);
        return addr[31:OFFSET_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU load/store port and line-oriented data-memory port of the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [31:0]           cpu_addr_i;
    logic [31:0]           cpu_wdata_i;
    logic [31:0]           cpu_rdata_o;
    logic                  cpu_stall_o;
    logic                  mem_ren_o;
    logic                  mem_wen_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0]     mem_wdata_o;
    logic [LINE_W-1:0]     mem_rdata_i;
    logic                  mem_ready_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ready_i,
        output cpu_rdata_o, cpu_stall_o, mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ready_i,
        input  cpu_rdata_o, cpu_stall_o, mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous line refill or word store.
module dcache_array #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned DATA_W    = 256
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [IDX_W-1:0]  index,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_line,
    input  logic              line_we,
    input  logic              word_we,
    input  logic [2:0]        word,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] line_in,
    input  logic [31:0]       word_in
);
    import dcache_pkg::*;

    logic [NUM_LINES-1:0] valid_bits;
    logic [NUM_LINES-1:0] dirty_bits;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [DATA_W-1:0]    lines [NUM_LINES];

    assign rd_valid = valid_bits[index];
    assign rd_dirty = dirty_bits[index];
    assign rd_tag   = tags[index];
    assign rd_line  = lines[index];

    // Only the state bits are cleared; tag and data survive reset.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (line_we) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (word_we) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            lines[index] <= line_in;
            tags[index]  <= tag_in;
        end else if (word_we) begin
            lines[index][word*WORD_W +: WORD_W] <= word_in;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: hit logic, miss FSM, mem-port registers.
module dcache_controller #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_W    = 256
) (
    input logic      clk_i,
    input logic      start_i,
    dcache_if.master bus
);
    import dcache_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - OFFSET_W - IDX_W;

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        word;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              hit;
    logic              line_we;
    logic              word_we;

    state_t                state_q, state_d;
    logic                  ren_q, ren_d;
    logic                  wen_q, wen_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;

    assign index = IDX_W'(addr_index(bus.cpu_addr_i, IDX_W));
    assign tag   = TAG_W'(addr_tag(bus.cpu_addr_i, IDX_W));
    assign word  = addr_word(bus.cpu_addr_i);

    // Array writes are suppressed during reset so a stale hit cannot commit.
    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .DATA_W    (LINE_W)
    ) u_array (
        .clk      (clk_i),
        .clear_n  (start_i),
        .index    (index),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_line  (line_data),
        .line_we  (line_we & start_i),
        .word_we  (word_we & start_i),
        .word     (word),
        .tag_in   (tag),
        .line_in  (bus.mem_rdata_i),
        .word_in  (bus.cpu_wdata_i)
    );

    assign hit             = line_valid && (line_tag == tag);
    assign bus.cpu_stall_o = bus.cpu_req_i && ((state_q != IDLE) || !hit);
    assign bus.cpu_rdata_o = line_data[word*WORD_W +: WORD_W];
    assign bus.mem_ren_o   = ren_q;
    assign bus.mem_wen_o   = wen_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        line_we = 1'b0;
        word_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        word_we = bus.cpu_we_i;
                    end else if (line_valid && line_dirty) begin
                        state_d = WRITEBACK;
                        wen_d   = 1'b1;
                        addr_d  = {line_tag, index};
                        wdata_d = line_data;
                    end else begin
                        state_d = ALLOCATE;
                        ren_d   = 1'b1;
                        addr_d  = addr_line(bus.cpu_addr_i);
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ready_i) begin
                    state_d = ALLOCATE;
                    wen_d   = 1'b0;
                    ren_d   = 1'b1;
                    addr_d  = addr_line(bus.cpu_addr_i);
                end
            end
            ALLOCATE: begin
                if (bus.mem_ready_i) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    line_we = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: 10-cycle line memory plus a flat-memory / tag-state reference model.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk   = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus ();

    dcache_controller #(.NUM_LINES(32), .LINE_W(256)) dut (
        .clk_i   (clk),
        .start_i (start),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        bit          timeout;
        int          ren_first;
        logic [26:0] ren_addr;
        int          wen_first;
        logic [26:0] wen_addr;
        logic [255:0] wen_wdata;
        bit          overlap;
        bit          unstable;
        int          exp_stall;
        logic [31:0] exp_rdata;
    } obs_t;

    // ---------------- backing memory ----------------
    logic [255:0] mem_lines [logic [26:0]];
    int mem_cnt = 0;

    function automatic logic [31:0] pat_word(input logic [26:0] la, input int k);
        logic [31:0] v;
        v = 32'(la) * 32'd8 + 32'(k) + 32'd1;
        return (v * 32'h9E3779B9) ^ 32'h0F0F1234;
    endfunction

    function automatic logic [255:0] get_line(input logic [26:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = pat_word(la, k);
        return l;
    endfunction

    // Ready pulses in the 11th cycle a request is visible.
    always @(posedge clk) begin
        if (!start || !(bus.mem_ren_o || bus.mem_wen_o)) begin
            mem_cnt <= 0;
            bus.mem_ready_i <= 1'b0;
        end else if (bus.mem_ready_i) begin
            mem_cnt <= 0;
            bus.mem_ready_i <= 1'b0;
        end else if (mem_cnt == 9) begin
            mem_cnt <= 0;
            bus.mem_ready_i <= 1'b1;
            if (bus.mem_wen_o) mem_lines[bus.mem_addr_o] = bus.mem_wdata_o;
            else bus.mem_rdata_i <= get_line(bus.mem_addr_o);
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    bit          m_valid [32];
    bit          m_dirty [32];
    int unsigned m_tag   [32];
    logic [31:0] shadow  [int unsigned];

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                output int exp_stall, output logic [31:0] exp_rdata);
        int unsigned idx, tg, wa;
        idx = int'(addr[9:5]);
        tg  = addr >> 10;
        wa  = addr >> 2;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_stall = 0;
        end else begin
            exp_stall = (m_valid[idx] && m_dirty[idx]) ? 23 : 12;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        exp_rdata = '0;
        if (we) begin
            shadow[wa]   = wdata;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_rdata = shadow.exists(wa) ? shadow[wa] : pat_word(addr[31:5], int'(addr[4:2]));
        end
    endtask

    // Dirty lines are lost on reset: the CPU view reverts to memory contents.
    task automatic model_reset();
        logic [26:0]  la;
        logic [255:0] l;
        for (int i = 0; i < 32; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                la = 27'((m_tag[i] << 5) | i);
                l  = get_line(la);
                for (int k = 0; k < 8; k++) shadow[32'(la) * 8 + 32'(k)] = l[k*32 +: 32];
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // ---------------- CPU driver ----------------
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
        bit prev_ren, prev_wen;
        logic [26:0]  prev_addr;
        logic [255:0] prev_wdata;
        int cyc;
        model_access(we, addr, wdata, o.exp_stall, o.exp_rdata);
        o.stall = 0; o.rdata = '0; o.timeout = 0;
        o.ren_first = -1; o.ren_addr = '0; o.wen_first = -1; o.wen_addr = '0; o.wen_wdata = '0;
        o.overlap = 0; o.unstable = 0;
        prev_ren = 0; prev_wen = 0; prev_addr = '0; prev_wdata = '0;
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wdata;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_ren_o && bus.mem_wen_o) o.overlap = 1;
            if (bus.mem_ren_o && o.ren_first < 0) begin o.ren_first = cyc; o.ren_addr = bus.mem_addr_o; end
            if (bus.mem_wen_o && o.wen_first < 0) begin
                o.wen_first = cyc; o.wen_addr = bus.mem_addr_o; o.wen_wdata = bus.mem_wdata_o;
            end
            if (((prev_ren && bus.mem_ren_o) || (prev_wen && bus.mem_wen_o)) &&
                (bus.mem_addr_o != prev_addr || bus.mem_wdata_o != prev_wdata)) o.unstable = 1;
            prev_ren = bus.mem_ren_o; prev_wen = bus.mem_wen_o;
            prev_addr = bus.mem_addr_o; prev_wdata = bus.mem_wdata_o;
            if (!bus.cpu_stall_o) begin o.rdata = bus.cpu_rdata_o; break; end
            o.stall++;
            if (o.stall > 200) begin o.timeout = 1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_ren_o !== 1'b0) begin errors++; $display("FAIL reset_ren: got %0b expected 0", bus.mem_ren_o); end
        checks++; if (bus.mem_wen_o !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", bus.mem_wen_o); end
        checks++; if (bus.mem_addr_o !== 27'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o); end
        checks++; if (bus.mem_wdata_o !== 256'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata_o); end
        checks++; if (bus.cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %0b expected 0", bus.cpu_stall_o); end
        bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 32'h40;
        #1;
        checks++; if (bus.cpu_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %0b expected 1", bus.cpu_stall_o); end
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        model_reset();
    endtask

    task automatic test_cold_miss();
        obs_t o;
        access(0, 32'h40, 32'h0, o);
        checks++; if (o.ren_first !== 1) begin errors++; $display("FAIL cold_ren_cycle: got %0d expected 1", o.ren_first); end
        checks++; if (o.ren_addr !== 27'd2) begin errors++; $display("FAIL cold_ren_addr: got %h expected 2", o.ren_addr); end
        checks++; if (o.wen_first !== -1) begin errors++; $display("FAIL cold_no_wen: got %0d expected -1", o.wen_first); end
        checks++; if (o.stall !== 12) begin errors++; $display("FAIL cold_stall: got %0d expected 12", o.stall); end
        checks++; if (o.rdata !== pat_word(27'd2, 0)) begin errors++; $display("FAIL cold_rdata: got %h expected %h", o.rdata, pat_word(27'd2, 0)); end
    endtask

    task automatic test_store_load_hit();
        obs_t o;
        access(1, 32'h44, 32'hDEADBEEF, o);
        checks++; if (o.stall !== 0) begin errors++; $display("FAIL st_hit_stall: got %0d expected 0", o.stall); end
        checks++; if (o.ren_first !== -1 || o.wen_first !== -1) begin errors++; $display("FAIL st_hit_mem: got ren %0d wen %0d expected -1 -1", o.ren_first, o.wen_first); end
        access(0, 32'h44, 32'h0, o);
        checks++; if (o.stall !== 0) begin errors++; $display("FAIL ld_hit_stall: got %0d expected 0", o.stall); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_hit_rdata: got %h expected deadbeef", o.rdata); end
        checks++; if (dut.u_array.dirty_bits[2] !== 1'b1) begin errors++; $display("FAIL ld_hit_dirty: got %0b expected 1", dut.u_array.dirty_bits[2]); end
    endtask

    task automatic test_dirty_evict();
        obs_t o;
        access(0, 32'h440, 32'h0, o);
        checks++; if (o.wen_first !== 1) begin errors++; $display("FAIL evict_wen_cycle: got %0d expected 1", o.wen_first); end
        checks++; if (o.wen_addr !== 27'd2) begin errors++; $display("FAIL evict_wen_addr: got %h expected 2", o.wen_addr); end
        checks++; if (o.wen_wdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL evict_wdata: got %h expected deadbeef", o.wen_wdata[63:32]); end
        checks++; if (o.ren_first !== 12) begin errors++; $display("FAIL evict_ren_cycle: got %0d expected 12", o.ren_first); end
        checks++; if (o.ren_addr !== 27'h22) begin errors++; $display("FAIL evict_ren_addr: got %h expected 22", o.ren_addr); end
        checks++; if (o.stall !== 23) begin errors++; $display("FAIL evict_stall: got %0d expected 23", o.stall); end
        checks++; if (get_line(27'd2) !== {pat_word(27'd2, 7), pat_word(27'd2, 6), pat_word(27'd2, 5), pat_word(27'd2, 4),
                                           pat_word(27'd2, 3), pat_word(27'd2, 2), 32'hDEADBEEF, pat_word(27'd2, 0)}) begin
            errors++; $display("FAIL evict_mem_line: got %h", get_line(27'd2));
        end
        checks++; if (o.rdata !== pat_word(27'h22, 0)) begin errors++; $display("FAIL evict_rdata: got %h expected %h", o.rdata, pat_word(27'h22, 0)); end
    endtask

    task automatic test_write_miss();
        obs_t o;
        logic [31:0] exp;
        access(1, 32'h68, 32'h1234, o);
        checks++; if (o.stall !== 12) begin errors++; $display("FAIL wmiss_stall: got %0d expected 12", o.stall); end
        for (int k = 0; k < 8; k++) begin
            access(0, 32'h60 + 32'(k) * 4, 32'h0, o);
            exp = (k == 2) ? 32'h1234 : pat_word(27'd3, k);
            checks++; if (o.rdata !== exp || o.stall !== 0) begin
                errors++; $display("FAIL wmiss_word%0d: got %h stall %0d expected %h stall 0", k, o.rdata, o.stall, exp);
            end
        end
    endtask

    task automatic test_handshake();
        obs_t o;
        logic [31:0] v;
        v = $urandom;
        access(1, 32'hA0, v, o);
        checks++; if (o.stall !== o.exp_stall) begin errors++; $display("FAIL hs_fill_stall: got %0d expected %0d", o.stall, o.exp_stall); end
        access(0, 32'h4A0, 32'h0, o);
        checks++; if (o.overlap !== 1'b0) begin errors++; $display("FAIL hs_overlap: got %0b expected 0", o.overlap); end
        checks++; if (o.unstable !== 1'b0) begin errors++; $display("FAIL hs_stable: got %0b expected 0", o.unstable); end
        checks++; if (o.wen_wdata[31:0] !== v) begin errors++; $display("FAIL hs_victim: got %h expected %h", o.wen_wdata[31:0], v); end
        checks++; if (o.stall !== 23) begin errors++; $display("FAIL hs_stall: got %0d expected 23", o.stall); end
        checks++; if (o.rdata !== o.exp_rdata) begin errors++; $display("FAIL hs_rdata: got %h expected %h", o.rdata, o.exp_rdata); end
    endtask

    task automatic test_reset_mid_miss();
        obs_t o;
        int n;
        n = 0;
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h80; bus.cpu_wdata_i = '0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (bus.mem_ren_o) n++;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL rmid_ren_seen: got %0d expected 5", n); end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.mem_ren_o !== 1'b0) begin errors++; $display("FAIL rmid_ren_drop: got %0b expected 0", bus.mem_ren_o); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d expected %0d", dut.state_q, IDLE); end
        bus.cpu_req_i = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        model_reset();
        access(0, 32'h80, 32'h0, o);
        checks++; if (o.ren_first !== 1 || o.stall !== 12) begin errors++; $display("FAIL rmid_refetch: got ren %0d stall %0d expected 1 12", o.ren_first, o.stall); end
        checks++; if (o.rdata !== pat_word(27'd4, 0)) begin errors++; $display("FAIL rmid_rdata: got %h expected %h", o.rdata, pat_word(27'd4, 0)); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a;
        bit we;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
            access(we, a, $urandom, o);
            checks++; if (o.timeout || o.stall !== o.exp_stall) begin
                errors++; $display("FAIL rand_stall[%0d] addr %h: got %0d expected %0d", i, a, o.stall, o.exp_stall);
            end
            checks++; if (o.overlap || o.unstable) begin
                errors++; $display("FAIL rand_handshake[%0d]: got overlap %0b unstable %0b expected 0 0", i, o.overlap, o.unstable);
            end
            if (!we) begin
                checks++; if (o.rdata !== o.exp_rdata) begin
                    errors++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, a, o.rdata, o.exp_rdata);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_store_load_hit();
        test_dirty_evict();
        test_write_miss();
        test_handshake();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache sitting between the CPU's 32-bit load/store port and the 256-bit line-oriented data memory. It is the initiator side of the data-memory protocol: it drives `mem_ren_o`/`mem_wen_o`/`mem_addr_o`/`mem_wdata_o`, waits for the one-cycle `mem_ready_i` pulse, and stalls the CPU on misses. Hits complete in the request cycle.

## Interface
Parameters:
- `NUM_LINES`, 32: cache lines, power of two; `IDX_W = log2(NUM_LINES)`.
- `LINE_W`, 256: line width in bits, fixed at 8 words, 32 bytes.

Ports:
- `clk_i`  in  1  single clock.
- `start_i`  in  1  synchronous active-low reset; low = held in reset.
- `cpu_req_i`  in  1  load/store request.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address, word-aligned; bits [1:0] ignored.
- `cpu_wdata_i`  in  32  store data.
- `cpu_rdata_o`  out  32  load data, valid when `cpu_req_i & ~cpu_we_i & ~cpu_stall_o`.
- `cpu_stall_o`  out  1  CPU must hold all `cpu_*` inputs stable while high.
- `mem_ren_o`  out  1  line read request, registered.
- `mem_wen_o`  out  1  line write request, registered.
- `mem_addr_o`  out  27  line address, byte address [31:5].
- `mem_wdata_o`  out  256  victim line data.
- `mem_rdata_i`  in  256  refill data, valid only while `mem_ready_i`.
- `mem_ready_i`  in  1  one-cycle completion pulse.

## Operation
- Address split: word = addr[4:2]; index = addr[5+IDX_W-1:5]; tag = addr[31:5+IDX_W].
- Hit = `valid[index] & (tag_arr[index] == tag)`. Hit, stall and `cpu_rdata_o` are combinational from the arrays and inputs.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- **IDLE**
  - Read hit: return the selected word.
  - Write hit: at the edge, write the word into the line and set `dirty[index]`.
  - Miss with valid and dirty victim: go to WRITEBACK and set `mem_wen_o=1`, `mem_addr_o={tag_arr[index],index}`, `mem_wdata_o=line`.
  - Miss otherwise: go to ALLOCATE and set `mem_ren_o=1`, `mem_addr_o=addr[31:5]`.
- **WRITEBACK**
  - Hold all mem outputs stable.
  - On `mem_ready_i`: clear `mem_wen_o`, set `mem_ren_o=1`, set `mem_addr_o=addr[31:5]`, go to ALLOCATE.
- **ALLOCATE**
  - Hold the request.
  - On `mem_ready_i`: capture `mem_rdata_i` into the line; set valid=1, dirty=0, tag=tag; clear `mem_ren_o`; go to IDLE.
  - The pending access then hits in the next cycle. A store merges after refill, never into refill data.
- `cpu_stall_o = cpu_req_i & (state != IDLE | ~hit)`.
- `mem_ren_o` and `mem_wen_o` are never high together. Each is high continuously from issue until the cycle after `mem_ready_i`.
- `mem_ready_i` seen in IDLE is ignored.
- No request (`cpu_req_i=0`): no array update and no state change.

## Timing
- Reset (`start_i` low at an edge):
  - state = IDLE; all valid and dirty bits = 0.
  - `mem_ren_o=0`, `mem_wen_o=0`, `mem_addr_o=0`, `mem_wdata_o=0`.
  - `cpu_stall_o` = `cpu_req_i` (every access misses). `cpu_rdata_o` is don't-care.
- Reset mid-miss abandons the transaction: outputs drop at that edge. Tag and data contents are not cleared.
- Hit latency: 0 cycles (same-cycle data, store committed at the next edge).
- With the 10-cycle data memory:
  - Clean miss: `cpu_stall_o` high for 12 cycles; data is returned in the 13th.
  - Dirty miss: stall for 23 cycles (11 for writeback, 12 for allocate).
- Mem outputs change only at edges where the FSM transitions. Address and write data never change while a request is high.

## Structure
- Package `dcache_pkg`:
  - FSM state enum (IDLE/WRITEBACK/ALLOCATE).
  - `LINE_W`, `WORD_W=32`, `OFFSET_W=5`, `MEM_ADDR_W=27`.
  - Address-field extraction helpers.
- Sub-module `dcache_array`:
  - Tag, valid, dirty and data storage.
  - Combinational read port.
  - Synchronous write port with full-line write (refill) and single-word write (store hit) modes.
  - Synchronous active-low clear of valid and dirty.
- `dcache_controller` holds the FSM, hit logic and mem-port registers.

## Test plan
- **Cold read miss.** After reset, load 0x0000_0040 with memory line 2 = pattern P.
  - `mem_ren_o` rises one edge after the request, `mem_addr_o=2`.
  - Stall lasts 12 cycles, then `cpu_rdata_o` = word 0 of P.
- **Store hit then load hit.** Store 0xDEADBEEF to 0x44, then load 0x44.
  - No mem activity.
  - Load returns 0xDEADBEEF in the same cycle; `dirty[2]=1`.
- **Dirty eviction.** After the previous test, load 0x0000_0440 (same index 2 for NUM_LINES=32, different tag).
  - `mem_wen_o` with addr 2 and wdata containing 0xDEADBEEF at word 1.
  - Then `mem_ren_o` with addr 0x22.
  - Stall 23 cycles; memory line 2 updated.
- **Write miss allocate.** Store 0x1234 to an uncached clean index.
  - Refill occurs and the store merges afterwards.
  - A subsequent load returns 0x1234 and the other 7 words equal memory.
- **Reset mid-miss.** Drop `start_i` during ALLOCATE.
  - `mem_ren_o=0` at that edge; state IDLE.
  - After release, the same load misses again and completes correctly.
- **Handshake stability.** Across a full dirty miss:
  - `mem_ren_o & mem_wen_o` is never 1.
  - `mem_addr_o` and `mem_wdata_o` are constant while either request is high.
